// File: rtl/b_vector_pkg.sv
// Shared types and widths for the bias/weight vector store blocks.
package b_vector_pkg;

   localparam int B_DATA_W = 16;
   localparam int B_ADDR_W = 9;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE,
      ST_READY
   } b_store_state_t;

   // Index width for a store of the given depth; a 1-entry store still needs a 1-bit index.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/b_vector_regfile.sv
// DEPTH x B_DATA_W flop array: one synchronous write port, one combinational
// read port, synchronous clear of every entry.
module b_vector_regfile
   import b_vector_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = ptr_width(DEPTH)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [B_DATA_W-1:0] wr_data,
   input  logic [AW-1:0]       rd_addr,
   output logic [B_DATA_W-1:0] rd_data
);

   logic [DEPTH-1:0][B_DATA_W-1:0] mem;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            mem[i] <= '0;
         end else if (clear) begin
            mem[i] <= '0;
         end else if (wr_en && (wr_addr == AW'(i))) begin
            mem[i] <= wr_data;
         end
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/b_vector_store.sv
// Bias vector store: streaming loader fills the regfile, manager reads it with 0-cycle latency.
// Define B_STORE_BOUNDS_CHECK_EN to reject addresses >= DEPTH and expose a sticky addr_error.
module b_vector_store
   import b_vector_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                clear,
   input  logic                load_start,
   input  logic                load_valid,
   input  logic [B_DATA_W-1:0] load_data,
   output logic                load_ready,
   output logic                load_done,
   output logic                store_valid,
   input  logic                external_b_requested,
   input  logic [B_ADDR_W-1:0] external_b_address,
`ifdef B_STORE_BOUNDS_CHECK_EN
   output logic                addr_error,
`endif
   output logic [B_DATA_W-1:0] external_b_element
);

   localparam int AW = ptr_width(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   b_store_state_t      state;
   logic [AW-1:0]       wr_ptr;
   logic                beat;
   logic                lookup_hit;
   logic                addr_legal;
   logic [B_DATA_W-1:0] rd_data;

   // load_ready is high exactly while in LOAD, so it doubles as the state qualifier.
   assign beat = load_valid && load_ready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         wr_ptr      <= '0;
         load_ready  <= 1'b0;
         load_done   <= 1'b0;
         store_valid <= 1'b0;
      end else if (clear) begin
         state       <= ST_IDLE;
         wr_ptr      <= '0;
         load_ready  <= 1'b0;
         load_done   <= 1'b0;
         store_valid <= 1'b0;
      end else begin
         load_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load_start) begin
                  state      <= ST_LOAD;
                  wr_ptr     <= '0;
                  load_ready <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (beat) begin
                  if (wr_ptr == LAST) begin
                     state      <= ST_DONE;
                     load_ready <= 1'b0;
                     load_done  <= 1'b1;
                  end else begin
                     wr_ptr <= wr_ptr + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state       <= ST_READY;
               store_valid <= 1'b1;
            end
            ST_READY: begin
               if (load_start) begin
                  state       <= ST_LOAD;
                  wr_ptr      <= '0;
                  store_valid <= 1'b0;
                  load_ready  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   b_vector_regfile #(
      .DEPTH(DEPTH)
   ) u_regfile (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear),
      .wr_en   (beat),
      .wr_addr (wr_ptr),
      .wr_data (load_data),
      .rd_addr (external_b_address[AW-1:0]),
      .rd_data (rd_data)
   );

   assign lookup_hit = store_valid && external_b_requested;

`ifdef B_STORE_BOUNDS_CHECK_EN
   assign addr_legal = (32'(external_b_address) < 32'(DEPTH));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_error <= 1'b0;
      end else if (clear) begin
         addr_error <= 1'b0;
      end else if (lookup_hit && !addr_legal) begin
         addr_error <= 1'b1;
      end
   end
`else
   // Without the check the address simply wraps modulo DEPTH; the high bits are dropped.
   assign addr_legal = 1'b1;

   if (AW < B_ADDR_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^external_b_address[B_ADDR_W-1:AW];
   end
`endif

   assign external_b_element = (lookup_hit && addr_legal) ? rd_data : '0;

endmodule

// File: tb/tb_b_vector_store.sv
// Randomized scoreboard bench for b_vector_store against a behavioural vector-store model.
module tb_b_vector_store;
   import b_vector_pkg::*;

   localparam int DEPTH = 16;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        clear = 1'b0;
   logic        load_start = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = '0;
   logic        load_ready;
   logic        load_done;
   logic        store_valid;
   logic        req = 1'b0;
   logic [8:0]  addr = '0;
   logic [15:0] element;
   logic        addr_err;

   b_vector_store #(.DEPTH(DEPTH)) dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .clear                (clear),
      .load_start           (load_start),
      .load_valid           (load_valid),
      .load_data            (load_data),
      .load_ready           (load_ready),
      .load_done            (load_done),
      .store_valid          (store_valid),
      .external_b_requested (req),
      .external_b_address   (addr),
`ifdef B_STORE_BOUNDS_CHECK_EN
      .addr_error           (addr_err),
`endif
      .external_b_element   (element)
   );

`ifndef B_STORE_BOUNDS_CHECK_EN
   assign addr_err = 1'b0;
`endif

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] elem;
      logic        sv;
      logic        lr;
      logic        ld;
      logic        err;
   } exp_t;

   exp_t sbq[$];

   // Behavioural model: phase 0 idle, 1 loading, 2 load just finished, 3 vector ready.
   int          m_phase = 0;
   int          m_cnt = 0;
   logic [15:0] m_mem[DEPTH];
   logic        m_err = 1'b0;
   int          exp_done = 0;
   int          act_done = 0;

   function automatic void model_clear();
      m_phase = 0;
      m_cnt   = 0;
      foreach (m_mem[i]) m_mem[i] = 16'h0000;
      m_err   = 1'b0;
   endfunction

   function automatic logic m_legal(input logic [8:0] a);
`ifdef B_STORE_BOUNDS_CHECK_EN
      return int'(a) < DEPTH;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [15:0] m_lookup(input logic [8:0] a);
      if (m_phase == 3 && m_legal(a)) return m_mem[int'(a) % DEPTH];
      return 16'h0000;
   endfunction

   function automatic void model_edge(input logic st, lv, input logic [15:0] d,
                                      input logic rq, input logic [8:0] a, input logic clr);
      if (clr) begin
         model_clear();
         return;
      end
      if (m_phase == 3 && rq && !m_legal(a)) m_err = 1'b1;
      case (m_phase)
         0: if (st) begin m_phase = 1; m_cnt = 0; end
         1: if (lv) begin
               m_mem[m_cnt] = d;
               m_cnt++;
               if (m_cnt == DEPTH) m_phase = 2;
            end
         2: m_phase = 3;
         3: if (st) begin m_phase = 1; m_cnt = 0; end
         default: m_phase = 0;
      endcase
   endfunction

   // One clock cycle: drive inputs, queue what the DUT must show this cycle, advance the model.
   task automatic cyc(input logic st, lv, input logic [15:0] d,
                      input logic rq, input logic [8:0] a, input logic clr);
      exp_t e;
      load_start = st; load_valid = lv; load_data = d; req = rq; addr = a; clear = clr;
      if (!reset_n) model_clear();
      if (m_phase == 2) exp_done++;
      if (rq) begin
         e.elem = m_lookup(a);
         e.sv   = (m_phase == 3);
         e.lr   = (m_phase == 1);
         e.ld   = (m_phase == 2);
         e.err  = m_err;
         sbq.push_back(e);
      end
      @(posedge clock);
      if (reset_n) model_edge(st, lv, d, rq, a, clr);
      #1;
   endtask

   function automatic void chk(input string n, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
      end
   endfunction

   always @(negedge clock) begin
      exp_t e;
      if (load_done === 1'b1) act_done++;
      if (req) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow: got empty queue expected an entry");
         end else begin
            e = sbq.pop_front();
            chk("element",     element,            e.elem);
            chk("store_valid", 16'(store_valid),   16'(e.sv));
            chk("load_ready",  16'(load_ready),    16'(e.lr));
            chk("load_done",   16'(load_done),     16'(e.ld));
            chk("addr_error",  16'(addr_err),      16'(e.err));
         end
      end
   end

   task automatic idle(input int n, input logic [8:0] a);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 1'b1, a, 1'b0);
   endtask

   initial begin
      model_clear();

      // Reset held, then released
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 1'b1, 9'd0, 1'b0);
      reset_n = 1'b1;
      idle(2, 9'd0);

      // Full back-to-back load of 0x0100+i
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 9'd5, 1'b0);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 16'(16'h0100 + i), 1'b1, 9'd5, 1'b0);
      idle(2, 9'd5);
      cyc(1'b0, 1'b1, 16'hDEAD, 1'b1, 9'd0, 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 16'h0, 1'b1, 9'($urandom_range(0, 15)), 1'b0);

      // Reload with a 3-cycle stall; lookups during LOAD must return 0
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 9'd3, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 7) for (int s = 0; s < 3; s++) cyc(1'b0, 1'b0, 16'h0, 1'b1, 9'd3, 1'b0);
         cyc(i == 4, 1'b1, 16'($urandom), 1'b1, 9'd3, 1'b0);
      end
      idle(1, 9'd3);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 16'h0, 1'b1, 9'(i), 1'b0);

      // Reload of 0xFFFF-i from READY
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 9'd15, 1'b0);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 16'(16'hFFFF - i), 1'b1, 9'd15, 1'b0);
      idle(3, 9'd15);

      // Out-of-range address, then clear
      idle(2, 9'd20);
      idle(3, 9'd4);
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 9'd511, 1'b0);
      idle(2, 9'd1);
      cyc(1'b0, 1'b0, 16'h0, 1'b1, 9'd1, 1'b1);
      idle(3, 9'd1);

      // Clear together with the final beat
      cyc(1'b1, 1'b0, 16'h0, 1'b1, 9'd0, 1'b0);
      for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 1'b1, 16'(16'h0A00 + i), 1'b1, 9'd2, 1'b0);
      cyc(1'b0, 1'b1, 16'h0A0F, 1'b1, 9'd2, 1'b1);
      idle(4, 9'd2);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic [8:0] a;
         a = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 31)) : 9'($urandom);
         cyc($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, 16'($urandom),
             $urandom_range(0, 3) != 0, a, $urandom_range(0, 149) == 0);
      end

      req = 1'b0;
      load_valid = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
      end
      chk("load_done_count", 16'(act_done), 16'(exp_done));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/b_vector_store.md
# b_vector_store

Responder side of the external bias-element interface: holds one bias vector of `DEPTH` signed 16-bit elements and answers the element manager's `external_b_requested` / `external_b_address` lookups with `external_b_element` in the same cycle. Contents are filled by a streaming load port (valid/ready) driven by the host loader before inference. The block sits between the host loader and the b-vector manager in the layer datapath.

## Interface

Parameters:
- `DEPTH`, 16: number of stored elements; a power of two, at most 512.

Ports:
- `clock`, input, 1: single clock; all state updates on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `clear`, input, 1: synchronous clear; same effect as reset, applied on the next edge.
- `load_start`, input, 1: one-cycle pulse that begins loading a new vector.
- `load_valid`, input, 1: `load_data` is valid this cycle.
- `load_data`, input, 16: next element, in order from index 0.
- `load_ready`, output, 1: the block accepts a beat this cycle.
- `load_done`, output, 1: one-cycle pulse after the last element is written.
- `store_valid`, output, 1: the vector is complete and lookups are served.
- `external_b_requested`, input, 1: lookup strobe from the manager.
- `external_b_address`, input, 9: element address.
- `external_b_element`, output, 16: looked-up element.
- `addr_error`, output, 1: sticky out-of-range flag. Present only with `B_STORE_BOUNDS_CHECK_EN`.

## Operation

- FSM states: IDLE, LOAD, DONE, READY.
- **IDLE**
  - `load_start` moves the FSM to LOAD and sets `wr_ptr` to 0.
- **LOAD**
  - `load_ready` is 1.
  - A beat is accepted when `load_valid && load_ready`; it writes `mem[wr_ptr]` and increments `wr_ptr`.
  - On acceptance of the beat with `wr_ptr == DEPTH-1`, the FSM moves to DONE.
  - `load_start` is ignored in this state.
- **DONE**
  - Lasts one cycle.
  - `load_done` is 1 and `load_ready` is 0.
  - Next state is READY.
- **READY**
  - `store_valid` is 1.
  - `load_start` re-enters LOAD: `store_valid` drops on the next edge and `wr_ptr` is reset to 0. Old contents stay in place until overwritten.
- **Lookup (combinational)**
  - `external_b_element` = `mem[external_b_address]` when `store_valid && external_b_requested` and the address is legal.
  - In every other case it is 16'h0000.
- **Clear and reset**
  - Both return the FSM to IDLE, set `wr_ptr` to 0, zero all `mem` entries and clear `addr_error`.
  - Clear has priority over every simultaneous event, including the final load beat; in that case no `load_done` pulse is issued.
- `load_data` is stored verbatim. No arithmetic is applied to it.

## Timing

- Reset values: `load_ready` = 0, `load_done` = 0, `store_valid` = 0, `external_b_element` = 0, `addr_error` = 0.
- Lookup latency is 0 cycles. The manager registers `external_b_element` on the same edge on which it presents the address.
- A full load of `DEPTH` beats at back-to-back `load_valid` takes:
  - 1 cycle from the `load_start` edge into LOAD;
  - `DEPTH` beat cycles;
  - 1 cycle in DONE;
  - `store_valid` = 1 in the following cycle.
- `load_valid` gaps simply stall `wr_ptr`. There is no timeout.
- A lookup during LOAD or DONE returns 0, never partially loaded data.
- `wr_ptr` never wraps. The FSM leaves LOAD exactly at `DEPTH` beats, and extra `load_valid` beats arriving in DONE or READY are not accepted (`load_ready` = 0).

## Configuration

- `B_STORE_BOUNDS_CHECK_EN` defined:
  - An address is legal only if `external_b_address < DEPTH`.
  - A lookup with `external_b_requested && store_valid` and an illegal address returns 0.
  - The same event sets `addr_error`, which stays set until `clear` or reset.
- Not defined:
  - The `addr_error` port is absent.
  - The address is truncated to its low `$clog2(DEPTH)` bits, so every address is legal and wraps modulo `DEPTH`.

## Structure

- Shared package `b_vector_pkg` holds:
  - `B_DATA_W` = 16 and `B_ADDR_W` = 9;
  - the FSM state enum `b_store_state_t`, shared with future weight-store blocks.
- One sub-module, `b_vector_regfile`:
  - `DEPTH` x 16 flops;
  - one synchronous write port, one combinational read port, synchronous zeroing.
- The FSM, pointer, lookup gating and error flag live in the `b_vector_store` top.

## Test plan

- **Reset:** hold `reset_n` low, then release and request address 0 → `external_b_element` = 0, `store_valid` = 0, `load_ready` = 0.
- **Full load:** `load_start`, then 16 back-to-back beats 16'h0100+i → `load_done` pulses once in the DONE cycle and `store_valid` = 1 on the next cycle. Requesting address 5 then returns 16'h0105 in the same cycle.
- **Stalled load:** deassert `load_valid` for 3 cycles mid-load → `wr_ptr` holds and the final contents match the beat order. Requesting address 3 during LOAD returns 0.
- **Clear on last beat:** assert `clear` together with the 16th beat → no `load_done`, FSM in IDLE, lookups return 0.
- **Reload from READY:** pulse `load_start` in READY → `store_valid` = 0 on the next cycle. Load 16'hFFFF-i, then address 15 returns 16'hFFF0.
- **Out-of-range address (macro on):** request address 9'd20 → element 0 and `addr_error` = 1, which persists until `clear`. With the macro off, the same request returns `mem[4]`.
